cntr_checker: RTL and testbench

CNTR_CHECKER -- requirements
Module: cntr_checker

---
 rtl/cntr_checker.sv | 176 +++++++++++++++++
 tb/tb_cntr_checker.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cntr_checker.sv
// ---------------------------------------------------------------------------
// cntr_checker
//   Watches an external up/down counter and checks every step against the
//   value predicted from the previous sample and direction. After LOCK_LEN
//   consecutive correct steps it declares lock. Once locked, each mismatch
//   produces a one-cycle error pulse and increments a saturating 8-bit
//   error counter. The block also flags correct steps across the wrap
//   boundary and reports the direction of the last correct step.
//
//   Optional feature: define CNTR_CHK_STICKY_EN to add the err_sticky
//   output. That output latches any error and is cleared only by rst.
//
//   All outputs are registered. They reflect the comparison of the count
//   sampled at the previous rising edge, so the latency is one cycle.
// ---------------------------------------------------------------------------
module cntr_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_down,
  input  logic [WIDTH-1:0] count,
  output logic             locked,
  output logic             err_pulse,
  output logic [7:0]       err_cnt,
  output logic             wrap_pulse,
  output logic             dir
`ifdef CNTR_CHK_STICKY_EN
  ,
  output logic             err_sticky
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [3:0]       RUN_LEN  = 4'(LOCK_LEN);

  // Saturating increment for the error counter: it holds at 255 and never wraps.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       match_run_q, match_run_d;
  logic [WIDTH-1:0] prev_cnt_q, prev_cnt_d;
  logic             prev_ud_q, prev_ud_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic             dir_q, dir_d;
`ifdef CNTR_CHK_STICKY_EN
  logic             err_sticky_q, err_sticky_d;
`endif

  logic [WIDTH-1:0] exp_cnt;
  logic             match;
  logic             wrap_step;

  // Predict the next count from the last sample and compare the new count with it.
  always_comb begin
    exp_cnt   = prev_ud_q ? (prev_cnt_q + CNT_ONE) : (prev_cnt_q - CNT_ONE);
    match     = (count == exp_cnt);
    wrap_step = (prev_ud_q && (prev_cnt_q == CNT_MAX)) ||
                (!prev_ud_q && (prev_cnt_q == CNT_ZERO));
  end

  // Next-state logic for the tracking FSM and all registered outputs.
  always_comb begin
    state_d      = state_q;
    match_run_d  = match_run_q;
    // The sample is always taken, so tracking resynchronises on the new value after a mismatch.
    prev_cnt_d   = count;
    prev_ud_d    = up_down;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    err_cnt_d    = err_cnt_q;
    dir_d        = dir_q;
`ifdef CNTR_CHK_STICKY_EN
    err_sticky_d = err_sticky_q;
`endif

    unique case (state_q)
      IDLE: begin
        // No valid previous sample exists yet. Capture it and do not compare.
        state_d     = ACQ;
        match_run_d = 4'd0;
      end

      ACQ: begin
        if (match) begin
          wrap_pulse_d = wrap_step;
          dir_d        = prev_ud_q;
          match_run_d  = match_run_q + 4'd1;
          if ((match_run_q + 4'd1) == RUN_LEN) begin
            state_d = LOCK;
          end
        end else begin
          // A mismatch during acquisition only restarts the run. It is not reported as an error.
          match_run_d = 4'd0;
        end
      end

      LOCK: begin
        if (match) begin
          wrap_pulse_d = wrap_step;
          dir_d        = prev_ud_q;
        end else begin
          err_pulse_d  = 1'b1;
          err_cnt_d    = sat_inc8(err_cnt_q);
          state_d      = ACQ;
          match_run_d  = 4'd0;
`ifdef CNTR_CHK_STICKY_EN
          err_sticky_d = 1'b1;
`endif
        end
      end

      default: begin
        state_d     = IDLE;
        match_run_d = 4'd0;
      end
    endcase

    locked_d = (state_d == LOCK);
  end

  // State and output registers. Reset takes priority over any comparison.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      match_run_q  <= 4'd0;
      prev_cnt_q   <= '0;
      prev_ud_q    <= 1'b0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_cnt_q    <= 8'd0;
      wrap_pulse_q <= 1'b0;
      dir_q        <= 1'b0;
`ifdef CNTR_CHK_STICKY_EN
      err_sticky_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      match_run_q  <= match_run_d;
      prev_cnt_q   <= prev_cnt_d;
      prev_ud_q    <= prev_ud_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      err_cnt_q    <= err_cnt_d;
      wrap_pulse_q <= wrap_pulse_d;
      dir_q        <= dir_d;
`ifdef CNTR_CHK_STICKY_EN
      err_sticky_q <= err_sticky_d;
`endif
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_cnt    = err_cnt_q;
  assign wrap_pulse = wrap_pulse_q;
  assign dir        = dir_q;
`ifdef CNTR_CHK_STICKY_EN
  assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_cntr_checker.sv
// ---------------------------------------------------------------------------
// tb_cntr_checker
//   Table-driven bench for cntr_checker (WIDTH=4, LOCK_LEN=2). Each vector
//   holds the inputs driven before a rising edge and the outputs required
//   just after that edge. Expected records go into a scoreboard queue when
//   the stimulus is driven and are popped when the outputs are sampled.
// ---------------------------------------------------------------------------
module tb_cntr_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_down;
  logic [3:0] count;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_cnt;
  logic       wrap_pulse;
  logic       dir;
`ifdef CNTR_CHK_STICKY_EN
  logic       err_sticky;
`endif

  cntr_checker #(.WIDTH(4), .LOCK_LEN(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_down    (up_down),
    .count      (count),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_cnt    (err_cnt),
    .wrap_pulse (wrap_pulse),
    .dir        (dir)
`ifdef CNTR_CHK_STICKY_EN
    ,
    .err_sticky (err_sticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ud;
    logic [3:0] cnt;
    logic       lk;
    logic       ep;
    logic [7:0] ec;
    logic       wp;
    logic       dr;
    logic       st;
    int         id;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic st_m    = 1'b0;

  // Append one vector. The expected sticky flag follows the error pulses in the table.
  task automatic add(input logic r, input logic ud, input logic [3:0] c,
                     input logic lk, input logic ep, input logic [7:0] ec,
                     input logic wp, input logic dr);
    vec_t v;
    v.rst = r; v.ud = ud; v.cnt = c;
    v.lk = lk; v.ep = ep; v.ec = ec; v.wp = wp; v.dr = dr;
    st_m  = r ? 1'b0 : (st_m | ep);
    v.st  = st_m;
    v.id  = vecs.size();
    vecs.push_back(v);
  endtask

  task automatic check_out();
    vec_t e;
    logic [12:0] got, want;
    logic st_got, st_want;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty: no expected record queued");
      return;
    end
    e = sb.pop_front();
`ifdef CNTR_CHK_STICKY_EN
    st_got  = err_sticky;
    st_want = e.st;
`else
    st_got  = 1'b0;
    st_want = 1'b0;
`endif
    got  = {locked, err_pulse, err_cnt, wrap_pulse, dir, st_got};
    want = {e.lk, e.ep, e.ec, e.wp, e.dr, st_want};
    if (got !== want) begin
      n_fail++;
      $display("FAIL vec%0d (cnt=%0d ud=%0d rst=%0d) lk/ep/ec/wp/dir/st got %b/%b/%0d/%b/%b/%b want %b/%b/%0d/%b/%b/%b",
               e.id, e.cnt, e.ud, e.rst,
               locked, err_pulse, err_cnt, wrap_pulse, dir, st_got,
               e.lk, e.ep, e.ec, e.wp, e.dr, st_want);
    end
  endtask

  task automatic apply(input vec_t v);
    rst     = v.rst;
    up_down = v.ud;
    count   = v.cnt;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic go(input logic r, input logic ud, input logic [3:0] c,
                    input logic lk, input logic ep, input logic [7:0] ec,
                    input logic wp, input logic dr);
    add(r, ud, c, lk, ep, ec, wp, dr);
    apply(vecs[vecs.size()-1]);
  endtask

  initial begin
    int c, c1, c2, n_tab;
    logic [7:0] ec;
    rst = 1'b1; up_down = 1'b0; count = 4'd0;

    // ---------------- vector table ----------------
    // args: rst, ud, cnt | locked, err_pulse, err_cnt, wrap_pulse, dir
    add(1, 0, 4'd0,  0, 0, 8'd0, 0, 0);
    add(1, 0, 4'd0,  0, 0, 8'd0, 0, 0);
    // Acquire from reset: 0 is captured without comparison, and lock comes after 2.
    add(0, 1, 4'd0,  0, 0, 8'd0, 0, 0);
    add(0, 1, 4'd1,  0, 0, 8'd0, 0, 1);
    add(0, 1, 4'd2,  1, 0, 8'd0, 0, 1);
    add(0, 1, 4'd3,  1, 0, 8'd0, 0, 1);
    for (int k = 4; k <= 15; k++) add(0, 1, 4'(k), 1, 0, 8'd0, 0, 1);
    // Upward wrap: 15 -> 0.
    add(0, 1, 4'd0,  1, 0, 8'd0, 1, 1);
    add(0, 1, 4'd1,  1, 0, 8'd0, 0, 1);
    // Direction change at 5.
    add(0, 1, 4'd2,  1, 0, 8'd0, 0, 1);
    add(0, 1, 4'd3,  1, 0, 8'd0, 0, 1);
    add(0, 1, 4'd4,  1, 0, 8'd0, 0, 1);
    add(0, 1, 4'd5,  1, 0, 8'd0, 0, 1);
    add(0, 0, 4'd6,  1, 0, 8'd0, 0, 1);
    add(0, 0, 4'd5,  1, 0, 8'd0, 0, 0);
    add(0, 0, 4'd4,  1, 0, 8'd0, 0, 0);
    // Back to up: 3 matches the down step, then 4 and 5; 9 is an error, then 10 and 11 relock.
    add(0, 1, 4'd3,  1, 0, 8'd0, 0, 0);
    add(0, 1, 4'd4,  1, 0, 8'd0, 0, 1);
    add(0, 1, 4'd5,  1, 0, 8'd0, 0, 1);
    add(0, 1, 4'd9,  0, 1, 8'd1, 0, 1);
    add(0, 1, 4'd10, 0, 0, 8'd1, 0, 1);
    add(0, 1, 4'd11, 1, 0, 8'd1, 0, 1);
    // A held count is an error.
    add(0, 1, 4'd11, 0, 1, 8'd2, 0, 1);
    add(0, 1, 4'd12, 0, 0, 8'd2, 0, 1);
    add(0, 1, 4'd13, 1, 0, 8'd2, 0, 1);
    add(0, 1, 4'd0,  0, 1, 8'd3, 0, 1);
    // A mismatch during acquisition is silent.
    add(0, 1, 4'd5,  0, 0, 8'd3, 0, 1);
    add(0, 1, 4'd6,  0, 0, 8'd3, 0, 1);
    add(0, 1, 4'd7,  1, 0, 8'd3, 0, 1);
    // Reset while locked with err_cnt=3, then IDLE capture and a downward wrap in ACQ.
    add(1, 1, 4'd7,  0, 0, 8'd0, 0, 0);
    add(0, 0, 4'd0,  0, 0, 8'd0, 0, 0);
    add(0, 0, 4'd15, 0, 0, 8'd0, 1, 0);
    add(0, 0, 4'd14, 1, 0, 8'd0, 0, 0);

    n_tab = vecs.size();
    for (int k = 0; k < n_tab; k++) apply(vecs[k]);

    // ---------------- saturation: 260 lock-mismatch-relock rounds ----------------
    c = 14;
    for (int i = 1; i <= 260; i++) begin
      ec = (i > 255) ? 8'd255 : 8'(i);
      go(0, 1, 4'(c), 0, 1, ec, 0, (i == 1) ? 1'b0 : 1'b1);
      c1 = (c + 1) % 16;
      go(0, 1, 4'(c1), 0, 0, ec, (c == 15) ? 1'b1 : 1'b0, 1);
      c2 = (c1 + 1) % 16;
      go(0, 1, 4'(c2), 1, 0, ec, (c1 == 15) ? 1'b1 : 1'b0, 1);
      c = c2;
    end
    c1 = (c + 1) % 16;
    go(0, 1, 4'(c1), 1, 0, 8'd255, (c == 15) ? 1'b1 : 1'b0, 1);
    // Only reset clears the saturated counter and the sticky flag.
    go(1, 0, 4'd0, 0, 0, 8'd0, 0, 0);
    go(0, 0, 4'd0, 0, 0, 8'd0, 0, 0);

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_leftover: %0d records left, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
